// File: rtl/spr_linebuf_wr.sv
// Sprite line buffer write stage.
// Non-transparent pixel pairs from the graphics mux are tagged with the slice
// palette and written into the current write bank. The opposite (display)
// bank is read out, and cleared as it is read, for the palette/video stage.
// Each bank is split into even/odd RAMs so the A and B pixels of a pair can
// always be written in the same cycle.
module spr_linebuf_wr #(
  parameter int LINE_W        = 384,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic        CLK_12M,
  input  logic        RESET,
  input  logic        SPR_START,
  input  logic [8:0]  SPR_X,
  input  logic [7:0]  SPR_PAL,
  input  logic        PIX_VALID,
  input  logic [3:0]  GAD,
  input  logic [3:0]  GBD,
  input  logic        LINE_SWAP,
  input  logic        RD_EN,
  input  logic [8:0]  RD_X,
  output logic [11:0] RD_DATA,
  output logic        BUSY,
  output logic        SLICE_DONE,
  output logic        WR_BANK
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_DRAW} state_t;

  state_t      state;
  logic [7:0]  clr_addr;
  logic [8:0]  cursor;
  logic [7:0]  pal;
  logic [2:0]  pair_cnt;

  // RAM index is {bank, parity}; entry address is X[8:1]
  logic [11:0] mem [0:3][0:255];

  logic        restart, draw_pv, wa_en, wb_en, rd_hit;
  logic [8:0]  x_a, x_b;
  logic [7:0]  pal_w;
  logic [1:0]  rd_sel;

  function automatic logic on_line(input logic [8:0] x);
    return {1'b0, x} < 10'(LINE_W);
  endfunction

  // A restart in DRAW takes effect immediately: a pair arriving in the same
  // cycle already belongs to the new slice
  assign restart = (state == S_DRAW) && SPR_START;
  assign draw_pv = (state == S_DRAW) && PIX_VALID;
  assign x_a     = restart ? SPR_X : cursor;
  assign x_b     = x_a + 9'd1;
  assign pal_w   = restart ? SPR_PAL : pal;
  assign wa_en   = draw_pv && (GAD != 4'd0) && on_line(x_a);
  assign wb_en   = draw_pv && (GBD != 4'd0) && on_line(x_b);
  assign rd_hit  = (state != S_CLEAR) && RD_EN && on_line(RD_X);
  assign rd_sel  = {~WR_BANK, RD_X[0]};

  // RAM writes: bulk clear, sprite pixels into write bank, clear-on-read
  always_ff @(posedge CLK_12M) begin
    if (!RESET) begin
      if (state == S_CLEAR) begin
        for (int b = 0; b < 4; b++) mem[b][clr_addr] <= '0;
      end else begin
        if (wa_en) mem[{WR_BANK, x_a[0]}][x_a[8:1]] <= {pal_w, GAD};
        if (wb_en) mem[{WR_BANK, x_b[0]}][x_b[8:1]] <= {pal_w, GBD};
        if (rd_hit && CLEAR_ON_READ) mem[rd_sel][RD_X[8:1]] <= '0;
      end
    end
  end

  // Control FSM, bank select and registered outputs
  always_ff @(posedge CLK_12M) begin
    if (RESET) begin
      state      <= S_CLEAR;
      clr_addr   <= '0;
      cursor     <= '0;
      pal        <= '0;
      pair_cnt   <= '0;
      RD_DATA    <= '0;
      BUSY       <= 1'b1;
      SLICE_DONE <= 1'b0;
      WR_BANK    <= 1'b0;
    end else begin
      SLICE_DONE <= 1'b0;
      case (state)
        S_CLEAR: begin
          RD_DATA  <= '0;
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == 8'd255) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (SPR_START) begin
            cursor   <= SPR_X;
            pal      <= SPR_PAL;
            pair_cnt <= '0;
            state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (PIX_VALID) begin
            cursor <= x_a + 9'd2;
            pal    <= pal_w;
            if (restart) begin
              pair_cnt <= 3'd1;
            end else if (pair_cnt == 3'd7) begin
              pair_cnt   <= '0;
              SLICE_DONE <= 1'b1;
              state      <= S_IDLE;
            end else begin
              pair_cnt <= pair_cnt + 3'd1;
            end
          end else if (restart) begin
            cursor   <= SPR_X;
            pal      <= SPR_PAL;
            pair_cnt <= '0;
          end
        end
        default: state <= S_CLEAR;
      endcase

      if (state != S_CLEAR) begin
        if (LINE_SWAP) WR_BANK <= ~WR_BANK;
        if (RD_EN) RD_DATA <= rd_hit ? mem[rd_sel][RD_X[8:1]] : 12'd0;
      end
    end
  end

endmodule

// File: tb/tb_spr_linebuf_wr.sv
// Directed bench for the sprite line buffer write stage.
module tb_spr_linebuf_wr;

  logic        clk = 1'b0;
  logic        RESET = 1'b0, SPR_START = 1'b0, PIX_VALID = 1'b0;
  logic        LINE_SWAP = 1'b0, RD_EN = 1'b0;
  logic [8:0]  SPR_X = '0, RD_X = '0;
  logic [7:0]  SPR_PAL = '0;
  logic [3:0]  GAD = '0, GBD = '0;
  logic [11:0] RD_DATA;
  logic        BUSY, SLICE_DONE, WR_BANK;

  int errors = 0;
  int checks = 0;

  spr_linebuf_wr #(.LINE_W(384), .CLEAR_ON_READ(1'b1)) dut (
    .CLK_12M(clk), .RESET(RESET), .SPR_START(SPR_START), .SPR_X(SPR_X),
    .SPR_PAL(SPR_PAL), .PIX_VALID(PIX_VALID), .GAD(GAD), .GBD(GBD),
    .LINE_SWAP(LINE_SWAP), .RD_EN(RD_EN), .RD_X(RD_X), .RD_DATA(RD_DATA),
    .BUSY(BUSY), .SLICE_DONE(SLICE_DONE), .WR_BANK(WR_BANK)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [8:0] x, output logic [11:0] d);
    RD_EN = 1'b1; RD_X = x;
    tick();
    RD_EN = 1'b0;
    d = RD_DATA;
  endtask

  task automatic start(input logic [8:0] x, input logic [7:0] p, inout int done);
    SPR_START = 1'b1; SPR_X = x; SPR_PAL = p;
    tick();
    SPR_START = 1'b0;
    if (SLICE_DONE) done++;
  endtask

  task automatic pair(input logic [3:0] a, input logic [3:0] b, inout int done);
    PIX_VALID = 1'b1; GAD = a; GBD = b;
    tick();
    PIX_VALID = 1'b0;
    if (SLICE_DONE) done++;
  endtask

  task automatic swap;
    LINE_SWAP = 1'b1;
    tick();
    LINE_SWAP = 1'b0;
  endtask

  task automatic test_reset;
    int n, bad;
    logic [11:0] d;
    RESET = 1'b1; LINE_SWAP = 1'b1; RD_EN = 1'b1; RD_X = 9'd5;
    tick();
    RESET = 1'b0;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", BUSY); end
    checks++; if (RD_DATA !== 12'h000) begin errors++; $display("FAIL reset_rd_data got=%h exp=000", RD_DATA); end
    checks++; if (WR_BANK !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got=%b exp=0", WR_BANK); end
    checks++; if (SLICE_DONE !== 1'b0) begin errors++; $display("FAIL reset_slice_done got=%b exp=0", SLICE_DONE); end
    n = 0;
    while (BUSY === 1'b1 && n < 400) begin tick(); n++; end
    LINE_SWAP = 1'b0; RD_EN = 1'b0;
    checks++; if (n !== 256) begin errors++; $display("FAIL busy_cycles got=%0d exp=256", n); end
    checks++; if (WR_BANK !== 1'b0) begin errors++; $display("FAIL swap_ignored_busy got=%b exp=0", WR_BANK); end
    checks++; if (RD_DATA !== 12'h000) begin errors++; $display("FAIL rd_ignored_busy got=%h exp=000", RD_DATA); end
    bad = 0;
    for (int x = 0; x < 384; x++) begin rd(9'(x), d); if (d !== 12'h000) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_disp_bank nonzero=%0d exp=0", bad); end
    swap();
    checks++; if (WR_BANK !== 1'b1) begin errors++; $display("FAIL swap_toggle got=%b exp=1", WR_BANK); end
    bad = 0;
    for (int x = 0; x < 384; x++) begin rd(9'(x), d); if (d !== 12'h000) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_wr_bank nonzero=%0d exp=0", bad); end
    swap();
  endtask

  task automatic test_basic;
    int done = 0;
    logic [11:0] d, e;
    logic [3:0] c;
    start(9'd16, 8'h2A, done);
    for (int i = 0; i < 8; i++) begin
      pair(4'(2*i+1), (i == 7) ? 4'd1 : 4'(2*i+2), done);
      checks++;
      if (SLICE_DONE !== (i == 7)) begin
        errors++; $display("FAIL basic_slice_done pair=%0d got=%b exp=%b", i, SLICE_DONE, (i == 7));
      end
    end
    tick();
    checks++; if (SLICE_DONE !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", SLICE_DONE); end
    checks++; if (done !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done); end
    swap();
    for (int k = 0; k < 16; k++) begin
      c = (k == 15) ? 4'd1 : 4'(k+1);
      e = {8'h2A, c};
      rd(9'(16+k), d);
      checks++; if (d !== e) begin errors++; $display("FAIL basic_read x=%0d got=%h exp=%h", 16+k, d, e); end
    end
  endtask

  task automatic test_overlap;
    int done = 0;
    logic [11:0] d;
    start(9'd100, 8'h01, done);
    for (int i = 0; i < 8; i++) pair(4'd5, 4'd5, done);
    start(9'd104, 8'h02, done);
    for (int i = 0; i < 8; i++) pair(4'd0, 4'd7, done);
    swap();
    rd(9'd104, d);
    checks++; if (d !== 12'h015) begin errors++; $display("FAIL ovl_x104 got=%h exp=015", d); end
    rd(9'd105, d);
    checks++; if (d !== 12'h027) begin errors++; $display("FAIL ovl_x105 got=%h exp=027", d); end
    rd(9'd100, d);
    checks++; if (d !== 12'h015) begin errors++; $display("FAIL ovl_x100 got=%h exp=015", d); end
    rd(9'd119, d);
    checks++; if (d !== 12'h027) begin errors++; $display("FAIL ovl_x119 got=%h exp=027", d); end
  endtask

  task automatic test_wrap;
    int done = 0;
    logic [11:0] d;
    start(9'd508, 8'h33, done);
    for (int i = 0; i < 8; i++) pair(4'd3, 4'd3, done);
    swap();
    for (int x = 0; x < 12; x++) begin
      rd(9'(x), d);
      checks++; if (d !== 12'h333) begin errors++; $display("FAIL wrap_read x=%0d got=%h exp=333", x, d); end
    end
    tick();
    checks++; if (RD_DATA !== 12'h333) begin errors++; $display("FAIL rd_hold got=%h exp=333", RD_DATA); end
    rd(9'd12, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL wrap_x12 got=%h exp=000", d); end
    rd(9'd508, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL offscreen_508 got=%h exp=000", d); end
    rd(9'd384, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL offscreen_384 got=%h exp=000", d); end
  endtask

  task automatic test_clear_swap;
    int done = 0;
    logic [11:0] d;
    start(9'd16, 8'h55, done);
    for (int i = 0; i < 7; i++) pair(4'd9, 4'd9, done);
    checks++; if (WR_BANK !== 1'b1) begin errors++; $display("FAIL pre_swap_bank got=%b exp=1", WR_BANK); end
    LINE_SWAP = 1'b1;
    pair(4'd9, 4'd9, done);
    LINE_SWAP = 1'b0;
    checks++; if (WR_BANK !== 1'b0) begin errors++; $display("FAIL post_swap_bank got=%b exp=0", WR_BANK); end
    rd(9'd30, d);
    checks++; if (d !== 12'h559) begin errors++; $display("FAIL swap_cycle_write got=%h exp=559", d); end
    rd(9'd16, d);
    checks++; if (d !== 12'h559) begin errors++; $display("FAIL cor_first got=%h exp=559", d); end
    rd(9'd16, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL cor_second got=%h exp=000", d); end
    swap();
    rd(9'd30, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL new_bank_untouched got=%h exp=000", d); end
  endtask

  task automatic test_abort;
    int done = 0;
    logic [11:0] d;
    start(9'd40, 8'h66, done);
    for (int i = 0; i < 3; i++) pair(4'd4, 4'd5, done);
    start(9'd200, 8'h77, done);
    for (int i = 0; i < 8; i++) pair(4'd6, 4'd7, done);
    tick();
    if (SLICE_DONE) done++;
    checks++; if (done !== 1) begin errors++; $display("FAIL abort_done_count got=%0d exp=1", done); end
    swap();
    rd(9'd40, d);
    checks++; if (d !== 12'h664) begin errors++; $display("FAIL abort_x40 got=%h exp=664", d); end
    rd(9'd45, d);
    checks++; if (d !== 12'h665) begin errors++; $display("FAIL abort_x45 got=%h exp=665", d); end
    rd(9'd46, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL abort_x46 got=%h exp=000", d); end
    rd(9'd200, d);
    checks++; if (d !== 12'h776) begin errors++; $display("FAIL abort_x200 got=%h exp=776", d); end
    rd(9'd215, d);
    checks++; if (d !== 12'h777) begin errors++; $display("FAIL abort_x215 got=%h exp=777", d); end
    rd(9'd216, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL abort_x216 got=%h exp=000", d); end
  endtask

  task automatic test_reset_mid;
    int done = 0;
    int n;
    logic [11:0] d;
    start(9'd60, 8'h12, done);
    for (int i = 0; i < 3; i++) pair(4'd1, 4'd1, done);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n = 0;
    while (BUSY === 1'b1 && n < 400) begin tick(); n++; end
    checks++; if (n !== 256) begin errors++; $display("FAIL mid_busy_cycles got=%0d exp=256", n); end
    checks++; if (WR_BANK !== 1'b0) begin errors++; $display("FAIL mid_wr_bank got=%b exp=0", WR_BANK); end
    swap();
    rd(9'd60, d);
    checks++; if (d !== 12'h000) begin errors++; $display("FAIL mid_discard got=%h exp=000", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_wrap();
    test_clear_swap();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spr_linebuf_wr.md
Name: spr_linebuf_wr

Overview:
- Sprite line-buffer stage directly downstream of the graphics mux. Consumes its per-cycle pixel-pair outputs (GAD = even pixel, GBD = odd pixel).
- Writes non-transparent pixels, tagged with the sprite palette, into a ping-pong pair of line buffers.
- The other buffer is read out to the palette/video stage and cleared as it is read.
- Bank roles swap on LINE_SWAP at each scanline boundary.

Parameters:
- LINE_W, 384, visible pixels per line; X >= LINE_W is never stored or read.
- CLEAR_ON_READ, 1, when 1 a read clears the location it reads.

Ports:
- CLK_12M  in  1  pixel clock
- RESET  in  1  synchronous active-high reset
- SPR_START  in  1  pulse: a new 16-pixel sprite slice begins; samples SPR_X/SPR_PAL
- SPR_X  in  9  X of the slice's first pixel
- SPR_PAL  in  8  palette number for the slice
- PIX_VALID  in  1  GAD/GBD carry a valid pixel pair
- GAD  in  4  colour index for pixel at cursor X
- GBD  in  4  colour index for pixel at cursor X+1
- LINE_SWAP  in  1  pulse: exchange write/display banks
- RD_EN  in  1  display read strobe
- RD_X  in  9  display read X
- RD_DATA  out  12  {pal[7:0], colour[3:0]}; 0 = transparent
- BUSY  out  1  post-reset clear in progress
- SLICE_DONE  out  1  one-cycle pulse after the 8th valid pair of a slice
- WR_BANK  out  1  bank currently receiving sprite writes

Behaviour:
- Storage: 2 banks × {even RAM, odd RAM}, each 256×12, addressed by X[8:1]. This gives two writes per cycle (A and B always hit opposite parity RAMs) and one read plus one clear per cycle on the display bank.
- States: CLEAR, IDLE, DRAW.
- CLEAR, entered on RESET:
  - A counter 0..255 writes 0 to all four RAMs at that address.
  - BUSY=1; SPR_START, PIX_VALID, RD_EN and LINE_SWAP are ignored; RD_DATA=0.
  - Exits to IDLE after address 255: 256 cycles, BUSY falls on cycle 257.
- Reset values: RD_DATA=0, BUSY=1, SLICE_DONE=0, WR_BANK=0; cursor, pair count and palette register = 0.
- IDLE → DRAW on SPR_START: cursor ← SPR_X, pal ← SPR_PAL, pair count ← 0. PIX_VALID is ignored in IDLE.
- DRAW, on each PIX_VALID:
  - Pixel A goes to address cursor, pixel B to cursor+1 (mod 512).
  - Each pixel is written only if colour ≠ 0 and address < LINE_W.
  - Then cursor ← cursor+2 (mod 512) and pair count +1.
- After the 8th pair: SLICE_DONE=1 for the next cycle, return to IDLE.
- SPR_START during DRAW aborts the current slice (no SLICE_DONE) and restarts with the new X/pal. A PIX_VALID in the same cycle belongs to the new slice at the new SPR_X.
- Overlap: the later write wins (later sprites have priority). No read-modify of existing data.
- Wrap: X 511 → 0 continues writing. The 384–511 range is dropped.
- Display read:
  - RD_EN with RD_X < LINE_W → RD_DATA = display-bank[RD_X], registered with 1-cycle latency.
  - If CLEAR_ON_READ, that location is written 0 in the same cycle (read-before-write).
  - RD_X ≥ LINE_W → RD_DATA=0 next cycle, no clear.
  - RD_EN=0 → RD_DATA holds.
- LINE_SWAP: WR_BANK toggles at the end of the cycle. Writes and reads in the swap cycle use the pre-swap banks. The swap does not disturb an in-progress slice: the cursor continues into the new write bank.
- RESET mid-slice or mid-line re-enters CLEAR and discards all buffered data.

Test Plan:
- Reset: assert RESET 1 cycle → BUSY=1 for 256 cycles, then 0. Every RD_X 0..383 on the display bank, and on the write bank after LINE_SWAP, returns 0.
- Basic slice: SPR_START X=16 pal=0x2A, 8 pairs (GAD,GBD)=(1,2),(3,4)…(15,1), LINE_SWAP, read X=16..31 → 0x2A1,0x2A2…0x2AF,0x2A1. SLICE_DONE pulses once, one cycle after the 8th pair.
- Transparency/overlap: slice A at X=100 all colour 5 pal 1, then slice B at X=104 colours alternating 0/7 pal 2 → after swap X=104 reads 0x015, X=105 reads 0x027, X=100 reads 0x015.
- Wrap/offscreen: slice at X=508, all colour 3 → addresses 508–511 dropped, X=0..11 read 0x<pal>3. Entries at X≥384 read 0 with no clear.
- Clear-on-read and swap collision: read X=16 twice → first cycle returns data, second returns 0. A pixel write in the same cycle as LINE_SWAP lands in the old write bank, and WR_BANK toggles the next cycle.
- Abort: SPR_START X=40, 3 pairs, SPR_START X=200, 8 pairs → X=40..45 written, X=200..215 written, exactly one SLICE_DONE.
